step_pulse_driver: RTL and testbench
====================================

# step_pulse_driver

Downstream stage of the tracking controller (`control_movimiento`). Converts the per-axis direction requests s_out_theta_pos/neg and s_out_phi_pos/neg into step/direction pulse trains for two stepper drivers. Integrates issued steps into 16-bit position counts, which the top level feeds back as theta_actual/phi_actual. Two identical, independent axis channels (theta, phi) share one clock.

## Interface
- CLK_DIV, 50000: step period in clk cycles; ≥ 2.
- PULSE_W, 100: step high time in cycles; 1 ≤ PULSE_W < CLK_DIV.
- DEAD_CYC, 1000: direction-change settle time in cycles; ≥ 1.
- POS_MIN, 0: lower soft limit (16-bit unsigned).
- POS_MAX, 180: upper soft limit; POS_MIN ≤ POS_RST ≤ POS_MAX.
- POS_RST, 90: position value loaded at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- theta_pos  in  1  request +theta step (from s_out_theta_pos).
- theta_neg  in  1  request −theta step.
- phi_pos  in  1  request +phi step.
- phi_neg  in  1  request −phi step.
- step_theta  out  1  theta step pulse.
- dir_theta  out  1  theta direction; 1 = positive.
- step_phi  out  1  phi step pulse.
- dir_phi  out  1  phi direction.
- theta_actual  out  16  theta position count.
- phi_actual  out  16  phi position count.
- busy_theta  out  1  theta FSM not in IDLE.
- busy_phi  out  1  phi FSM not in IDLE.

## Operation
The description below covers one axis. The other axis behaves identically and independently.
- Command decode:
  - pos&~neg → UP.
  - neg&~pos → DOWN.
  - pos&neg, or neither → NONE.
- A command is blocked (with limits enabled) in either case:
  - UP with position == POS_MAX.
  - DOWN with position == POS_MIN.
- FSM states: IDLE, DEAD, HI, LO.
- IDLE:
  - Unblocked command whose direction matches dir → HI.
  - Unblocked command whose direction differs from dir → DEAD. dir updates on the same edge.
  - NONE or blocked → stay in IDLE.
- DEAD:
  - Lasts exactly DEAD_CYC cycles.
  - If the command is still unblocked in dir's direction → HI; otherwise → IDLE.
- HI:
  - step = 1 for exactly PULSE_W cycles.
  - Position is ±1 on the edge that enters HI.
- LO:
  - step = 0 for CLK_DIV−PULSE_W cycles.
  - At the end: same-direction unblocked command → HI directly, with no IDLE cycle; otherwise → IDLE.
- A started step period is never truncated. Removing or reversing the command mid-period still completes HI and LO.
- dir never changes outside the IDLE→DEAD transition, so dir is stable throughout every step pulse.
- Both axes may step simultaneously. There is no arbitration between them.

## Timing
- Reset values:
  - step_* = 0, dir_* = 1, busy_* = 0.
  - theta_actual = phi_actual = POS_RST.
  - FSMs in IDLE, counters 0.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Same-direction start latency:
  - Command seen in IDLE at edge n.
  - step rises, busy rises, and position updates at edge n+1.
- Reverse-direction start:
  - dir toggles at edge n+1.
  - step rises at edge n+1+DEAD_CYC.
- Continuous command gives a step period of exactly CLK_DIV cycles and a duty of PULSE_W/CLK_DIV.
- Limit check uses the already-updated position. At the end of the LO that reached the limit, the FSM goes to IDLE.
- Asserting rst mid-pulse:
  - Forces step low immediately (asynchronous).
  - Reloads position to POS_RST.
  - No partial count is retained.

## Configuration
- STEP_SOFT_LIMITS_EN defined:
  - Blocking at POS_MIN/POS_MAX as above.
  - Position never leaves [POS_MIN, POS_MAX].
- Undefined:
  - No blocking.
  - Position counts wrap modulo 2^16 (0xFFFF +1 → 0x0000; 0x0000 −1 → 0xFFFF).
  - POS_MIN/POS_MAX are ignored.

## Test plan
Bench parameters: CLK_DIV=10, PULSE_W=3, DEAD_CYC=4, POS_MIN=0, POS_MAX=5, POS_RST=3, STEP_SOFT_LIMITS_EN defined unless stated.
- Reset mid-pulse → step_theta low within the same cycle, theta_actual=3, dir=1, busy=0. After release, stays idle with no command.
- theta_pos held 25 cycles from idle:
  - step high at cycles 1–3 and 11–13, period 10.
  - theta_actual 3→4→5, then blocked; busy drops after cycle 20.
  - No third pulse.
- phi_neg held after reset:
  - dir_phi 1→0 at cycle 1; first step at cycle 5.
  - phi_actual 3→2.
- theta_pos removed 1 cycle after step rise → full 3-cycle pulse plus 7-cycle LO, then IDLE. theta_actual changes by exactly 1.
- theta_pos=theta_neg=1 → no steps, busy_theta=0. Simultaneously, phi_pos alone steps phi normally.
- STEP_SOFT_LIMITS_EN undefined, POS_RST=0, phi_neg held → phi_actual 0x0000→0xFFFF→0xFFFE at a 10-cycle spacing.

Source files
------------

// File: rtl/step_pulse_driver.sv
// rtl/step_pulse_driver.sv - two-axis step/dir pulse generator with position counts
// Optional soft limits at POS_MIN/POS_MAX: define STEP_SOFT_LIMITS_EN.

module step_axis #(
  parameter int CLK_DIV  = 50000,
  parameter int PULSE_W  = 100,
  parameter int DEAD_CYC = 1000,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 180,
  parameter int POS_RST  = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_pos,
  input  logic        i_neg,
  output logic        o_step,
  output logic        o_dir,
  output logic        o_busy,
  output logic [15:0] o_pos
);
  localparam int CW = $clog2((CLK_DIV > DEAD_CYC) ? CLK_DIV : DEAD_CYC) + 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] HI_LAST   = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] LO_LAST   = CW'(CLK_DIV - PULSE_W - 1);
`ifdef STEP_SOFT_LIMITS_EN
  localparam bit LIMITS_EN = 1'b1;
`else
  localparam bit LIMITS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DEAD, S_HI, S_LO} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_dir, w_dir_next;
  logic [15:0]   r_pos, w_pos_next;
  logic          r_step, r_busy;
  logic          w_up, w_dn, w_blocked, w_ok, w_same, w_start;

  assign w_up      = i_pos & ~i_neg;
  assign w_dn      = i_neg & ~i_pos;
  assign w_blocked = LIMITS_EN && ((w_up && (r_pos == 16'(POS_MAX))) ||
                                   (w_dn && (r_pos == 16'(POS_MIN))));
  assign w_ok      = (w_up | w_dn) & ~w_blocked;
  // A step may only be issued in the direction already latched on dir
  assign w_same    = w_ok & (w_up == r_dir);

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_dir_next = r_dir;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_same) begin
          w_start = 1'b1;
        end else if (w_ok) begin
          w_next     = S_DEAD;
          w_cnt_next = '0;
          w_dir_next = w_up;
        end
      end
      S_DEAD: begin
        if (r_cnt == DEAD_LAST) begin
          if (w_same) w_start = 1'b1;
          else begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_HI: begin
        if (r_cnt == HI_LAST) begin
          w_next     = S_LO;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_LO: begin
        if (r_cnt == LO_LAST) begin
          if (w_same) w_start = 1'b1;
          else begin
            w_next     = S_IDLE;
            w_cnt_next = '0;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
    if (w_start) begin
      w_next     = S_HI;
      w_cnt_next = '0;
    end
    w_pos_next = r_pos;
    if (w_start) w_pos_next = r_dir ? (r_pos + 16'd1) : (r_pos - 16'd1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b1;
      r_pos   <= 16'(POS_RST);
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_dir   <= w_dir_next;
      r_pos   <= w_pos_next;
      r_step  <= (w_next == S_HI);
      r_busy  <= (w_next != S_IDLE);
    end
  end

  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_busy = r_busy;
  assign o_pos  = r_pos;
endmodule

module step_pulse_driver #(
  parameter int CLK_DIV  = 50000,
  parameter int PULSE_W  = 100,
  parameter int DEAD_CYC = 1000,
  parameter int POS_MIN  = 0,
  parameter int POS_MAX  = 180,
  parameter int POS_RST  = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        theta_pos,
  input  logic        theta_neg,
  input  logic        phi_pos,
  input  logic        phi_neg,
  output logic        step_theta,
  output logic        dir_theta,
  output logic        step_phi,
  output logic        dir_phi,
  output logic [15:0] theta_actual,
  output logic [15:0] phi_actual,
  output logic        busy_theta,
  output logic        busy_phi
);
  step_axis #(
    .CLK_DIV(CLK_DIV), .PULSE_W(PULSE_W), .DEAD_CYC(DEAD_CYC),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_RST(POS_RST)
  ) u_theta (
    .clk(clk), .rst(rst), .i_pos(theta_pos), .i_neg(theta_neg),
    .o_step(step_theta), .o_dir(dir_theta), .o_busy(busy_theta), .o_pos(theta_actual)
  );

  step_axis #(
    .CLK_DIV(CLK_DIV), .PULSE_W(PULSE_W), .DEAD_CYC(DEAD_CYC),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX), .POS_RST(POS_RST)
  ) u_phi (
    .clk(clk), .rst(rst), .i_pos(phi_pos), .i_neg(phi_neg),
    .o_step(step_phi), .o_dir(dir_phi), .o_busy(busy_phi), .o_pos(phi_actual)
  );
endmodule

// File: tb/tb_step_pulse_driver.sv
// tb/tb_step_pulse_driver.sv - randomized and directed check of step_pulse_driver against a period-level model
// Follows STEP_SOFT_LIMITS_EN exactly as the RTL does.

module tb_step_pulse_driver;
  localparam int CD = 10;
  localparam int PW = 3;
  localparam int DC = 4;
  localparam int PMIN = 0;
  localparam int PMAX = 5;
`ifdef STEP_SOFT_LIMITS_EN
  localparam bit LIM = 1'b1;
`else
  localparam bit LIM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] in_p = '0;
  logic [3:0] in_n = '0;
  wire  [3:0] o_step, o_dir, o_busy;
  wire  [63:0] o_pos;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  // Channels: 0 = A theta, 1 = A phi (reset pos 3), 2 = B theta, 3 = B phi (reset pos 0)
  step_pulse_driver #(.CLK_DIV(CD), .PULSE_W(PW), .DEAD_CYC(DC),
                      .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_RST(3)) dut_a (
    .clk(clk), .rst(rst),
    .theta_pos(in_p[0]), .theta_neg(in_n[0]), .phi_pos(in_p[1]), .phi_neg(in_n[1]),
    .step_theta(o_step[0]), .dir_theta(o_dir[0]), .step_phi(o_step[1]), .dir_phi(o_dir[1]),
    .theta_actual(o_pos[15:0]), .phi_actual(o_pos[31:16]),
    .busy_theta(o_busy[0]), .busy_phi(o_busy[1])
  );

  step_pulse_driver #(.CLK_DIV(CD), .PULSE_W(PW), .DEAD_CYC(DC),
                      .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_RST(0)) dut_b (
    .clk(clk), .rst(rst),
    .theta_pos(in_p[2]), .theta_neg(in_n[2]), .phi_pos(in_p[3]), .phi_neg(in_n[3]),
    .step_theta(o_step[2]), .dir_theta(o_dir[2]), .step_phi(o_step[3]), .dir_phi(o_dir[3]),
    .theta_actual(o_pos[47:32]), .phi_actual(o_pos[63:48]),
    .busy_theta(o_busy[2]), .busy_phi(o_busy[3])
  );

  task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, act, exp, $time);
    end
  endtask

  // Model: a channel is idle, settling after a reversal, or somewhere inside a CD-cycle step period
  int          m_mode [4];
  int          m_left [4];
  int          m_age  [4];
  bit          m_dir  [4];
  logic [15:0] m_pos  [4];

  function automatic logic [15:0] rst_pos(input int ch);
    return (ch < 2) ? 16'd3 : 16'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        m_mode[ch] = 0; m_left[ch] = 0; m_age[ch] = 0;
        m_dir[ch] = 1'b1; m_pos[ch] = rst_pos(ch);
      end
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        int  want;
        bit  ok, same, start;
        want = (in_p[ch] && !in_n[ch]) ? 1 : ((in_n[ch] && !in_p[ch]) ? 2 : 0);
        ok = (want != 0);
        if (LIM && want == 1 && m_pos[ch] == 16'(PMAX)) ok = 1'b0;
        if (LIM && want == 2 && m_pos[ch] == 16'(PMIN)) ok = 1'b0;
        same  = ok && ((want == 1) == m_dir[ch]);
        start = 1'b0;
        if (m_mode[ch] == 2) begin
          m_age[ch]++;
          if (m_age[ch] == CD) begin
            if (same) start = 1'b1; else m_mode[ch] = 0;
          end
        end else if (m_mode[ch] == 1) begin
          m_left[ch]--;
          if (m_left[ch] == 0) begin
            if (same) start = 1'b1; else m_mode[ch] = 0;
          end
        end else if (ok) begin
          if (same) start = 1'b1;
          else begin
            m_mode[ch] = 1; m_left[ch] = DC; m_dir[ch] = (want == 1);
          end
        end
        if (start) begin
          m_mode[ch] = 2; m_age[ch] = 0;
          m_pos[ch] = m_dir[ch] ? m_pos[ch] + 16'd1 : m_pos[ch] - 16'd1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      for (int ch = 0; ch < 4; ch++) begin
        check("step", ch, o_step[ch], (m_mode[ch] == 2 && m_age[ch] < PW));
        check("dir",  ch, o_dir[ch],  m_dir[ch]);
        check("busy", ch, o_busy[ch], (m_mode[ch] != 0));
        check("pos",  ch, o_pos[ch*16 +: 16], m_pos[ch]);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_p = '0; in_n = '0; rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int pulses, pulses_b, hi_cnt, busy_max;
    logic prev, prev_b, s1, s3, s4, s11, b10, b11, b21, d1;
    logic [15:0] p5, p15;

    do_reset();
    cmp_en = 1'b1;
    check("rst_step", 0, o_step[0], 1'b0);
    check("rst_dir",  0, o_dir[0],  1'b1);
    check("rst_busy", 0, o_busy[0], 1'b0);
    check("rst_pos",  0, o_pos[15:0], 16'd3);
    check("rst_pos",  3, o_pos[63:48], 16'd0);

    // Reset arriving in the middle of a step pulse
    in_p[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_step", 0, o_step[0], 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_step", 0, o_step[0], 1'b0);
    check("midrst_pos",  0, o_pos[15:0], 16'd3);
    check("midrst_dir",  0, o_dir[0], 1'b1);
    check("midrst_busy", 0, o_busy[0], 1'b0);
    @(negedge clk);
    in_p[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    busy_max = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_busy[0] || o_step[0]) busy_max = 1;
    end
    check("idle_after_rst", 0, busy_max, 0);

    // theta_pos held 25 cycles
    do_reset();
    in_p[0] = 1'b1; prev = 1'b0; pulses = 0;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk);
      if (o_step[0] && !prev) pulses++;
      prev = o_step[0];
      if (i == 1) s1 = o_step[0];
      if (i == 3) s3 = o_step[0];
      if (i == 4) s4 = o_step[0];
      if (i == 11) s11 = o_step[0];
      if (i == 21) b21 = o_busy[0];
    end
    in_p[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("t25_s1",  0, s1, 1'b1);
    check("t25_s3",  0, s3, 1'b1);
    check("t25_s4",  0, s4, 1'b0);
    check("t25_s11", 0, s11, 1'b1);
    check("t25_busy21", 0, b21, LIM ? 1'b0 : 1'b1);
    check("t25_pulses", 0, pulses, LIM ? 2 : 3);
    check("t25_pos", 0, o_pos[15:0], LIM ? 16'd5 : 16'd6);

    // phi_neg from reset: reversal settle then step
    do_reset();
    in_n[1] = 1'b1; hi_cnt = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) d1 = o_dir[1];
      if (i <= 4 && o_step[1]) hi_cnt++;
      if (i == 5) s1 = o_step[1];
    end
    in_n[1] = 1'b0;
    repeat (12) @(negedge clk);
    check("phineg_dir1", 1, d1, 1'b0);
    check("phineg_early_step", 1, hi_cnt, 0);
    check("phineg_step5", 1, s1, 1'b1);
    check("phineg_pos", 1, o_pos[31:16], 16'd2);

    // Command removed one cycle after the step rises
    do_reset();
    in_p[0] = 1'b1; hi_cnt = 0; pulses = 0; prev = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 2) in_p[0] = 1'b0;
      if (o_step[0]) hi_cnt++;
      if (o_step[0] && !prev) pulses++;
      prev = o_step[0];
      if (i == 10) b10 = o_busy[0];
      if (i == 11) b11 = o_busy[0];
    end
    check("rm_hi_cnt", 0, hi_cnt, 3);
    check("rm_pulses", 0, pulses, 1);
    check("rm_busy10", 0, b10, 1'b1);
    check("rm_busy11", 0, b11, 1'b0);
    check("rm_pos", 0, o_pos[15:0], 16'd4);

    // Conflicting theta command alongside a normal phi command
    do_reset();
    in_p[0] = 1'b1; in_n[0] = 1'b1; in_p[1] = 1'b1;
    busy_max = 0; pulses = 0; pulses_b = 0; prev = 1'b0; prev_b = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (o_busy[0] || o_step[0]) busy_max = 1;
      if (o_step[0] && !prev) pulses++;
      if (o_step[1] && !prev_b) pulses_b++;
      prev = o_step[0]; prev_b = o_step[1];
    end
    in_p = '0; in_n = '0;
    repeat (12) @(negedge clk);
    check("both_theta_busy", 0, busy_max, 0);
    check("both_theta_pulses", 0, pulses, 0);
    check("both_phi_pulses", 1, pulses_b, 2);
    check("both_phi_pos", 1, o_pos[31:16], 16'd5);

    // Wrap (or block) below zero on the POS_RST=0 instance
    do_reset();
    in_n[3] = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 5) p5 = o_pos[63:48];
      if (i == 15) p15 = o_pos[63:48];
    end
    in_n[3] = 1'b0;
    repeat (12) @(negedge clk);
    check("wrap_p5",  3, p5,  LIM ? 16'h0000 : 16'hFFFF);
    check("wrap_p15", 3, p15, LIM ? 16'h0000 : 16'hFFFE);

    // Random commands on all four channels
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int ch = 0; ch < 4; ch++) begin
        if ($urandom_range(5) == 0) begin
          in_p[ch] = 1'($urandom_range(1));
          in_n[ch] = 1'($urandom_range(1));
        end
      end
    end
    in_p = '0; in_n = '0;
    repeat (25) @(negedge clk);
    busy_max = 0;
    for (int ch = 0; ch < 4; ch++) if (o_busy[ch]) busy_max = 1;
    check("drain_idle", 0, busy_max, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
